list_builder: RTL and testbench

Writer-side counterpart to the list-sum traversal controller: accepts a stream of data words over a valid/ready handshake and lays them out in word-addressed memory as a singly linked list that the traversal datapath walks. The list ends in a null next pointer, which is what the traversal side detects as `next_zero`. Control FSM and address/pointer datapath are contained in one block. The block drives the memory write port directly and reports the list head and node count on completion.

---
 rtl/list_pkg.sv | 20 ++
 rtl/list_builder.sv | 138 +++++++++++++
 tb/tb_list_builder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/list_pkg.sv
// Shared definitions for the linked-list writer and the traversal side that walks it.
package list_pkg;

  // One-hot control states of the list builder.
  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_WAIT    = 5'b00010,
    S_WR_VAL  = 5'b00100,
    S_WR_LINK = 5'b01000,
    S_DONE    = 5'b10000
  } lb_state_t;

  // A next pointer of zero terminates the list.
  localparam int NULL_PTR    = 0;
  // Each node occupies two consecutive words: value then link.
  localparam int NODE_STRIDE = 2;
  localparam int VAL_OFS     = 0;
  localparam int LINK_OFS    = 1;

endpackage

// File: rtl/list_builder.sv
// Accepts a stream of words and writes them to memory as a null-terminated singly linked list.
module list_builder
  import list_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int BASE_ADDR = 2,
  parameter int MAX_NODES = 64,
  localparam int CW       = $clog2(MAX_NODES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] head_addr,
  output logic [CW-1:0] node_count,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  // Elaboration-time guards: node 0 must not sit at the null address, and the
  // last link word must fit below 2**AW so pointer arithmetic never wraps.
  if ((BASE_ADDR % NODE_STRIDE) != 0 || BASE_ADDR == 0) begin : g_bad_base
    $error("list_builder: BASE_ADDR must be even and nonzero");
  end
  if ((BASE_ADDR + NODE_STRIDE * MAX_NODES - 1) >= (1 << AW)) begin : g_bad_range
    $error("list_builder: list does not fit in the address space");
  end

  lb_state_t     state;
  lb_state_t     state_nxt;
  logic [AW-1:0] node_ptr;
  logic [AW-1:0] next_ptr;
  logic [DW-1:0] cap_data;
  logic          cap_last;
  logic          at_capacity;
  logic          is_tail;

  assign next_ptr    = node_ptr + AW'(NODE_STRIDE);
  assign at_capacity = (node_count == CW'(MAX_NODES - 1));
  assign is_tail     = cap_last || at_capacity;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore output decode from registered state and datapath.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_WR_VAL;
      end
      S_WR_VAL: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = node_ptr + AW'(VAL_OFS);
        mem_wdata = cap_data;
        state_nxt = S_WR_LINK;
      end
      S_WR_LINK: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = node_ptr + AW'(LINK_OFS);
        if (is_tail) begin
          mem_wdata = DW'(NULL_PTR);
          state_nxt = S_DONE;
        end else begin
          mem_wdata = DW'(next_ptr);
          state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Node pointer, capture, head, count and overflow registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      node_ptr   <= '0;
      cap_data   <= '0;
      cap_last   <= 1'b0;
      head_addr  <= '0;
      node_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            node_ptr   <= AW'(BASE_ADDR);
            node_count <= '0;
            overflow   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            cap_data <= in_data;
            cap_last <= in_last;
          end
        end
        S_WR_VAL: begin
          if (node_count == '0) head_addr <= AW'(BASE_ADDR);
        end
        S_WR_LINK: begin
          node_count <= node_count + 1'b1;
          if (!is_tail) node_ptr <= next_ptr;
          if (!cap_last && at_capacity) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_list_builder.sv
// Self-checking bench for list_builder: table vectors, corner sequences and random lists.
module tb_list_builder;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int BASE = 2;
  localparam int MAXN = 4;
  localparam int CW   = $clog2(MAXN + 1);

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, in_last;
  logic          mem_we, busy, done, overflow;
  logic [DW-1:0] in_data, mem_wdata;
  logic [AW-1:0] mem_addr, head_addr;
  logic [CW-1:0] node_count;

  always #5 clk = ~clk;

  list_builder #(.DW(DW), .AW(AW), .BASE_ADDR(BASE), .MAX_NODES(MAXN)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .head_addr(head_addr), .node_count(node_count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_xfer = 0;
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  logic [DW-1:0] vals_q[$];
  bit            last_q[$];
  int            wbase, xbase;

  // Write and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (in_valid && in_ready) n_xfer++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the list is cut at the first in_last or at capacity,
  // whichever comes first; overflow means capacity ended it.
  function automatic void model(output int n, output bit ovf);
    n = 0;
    for (int i = 0; i < vals_q.size(); i++) begin
      n++;
      if (last_q[i] || n == MAXN) break;
    end
    ovf = (n > 0) ? !last_q[n-1] : 1'b0;
  endfunction

  task automatic send(input logic [DW-1:0] d, input bit l, input int idle, output bit ok);
    in_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_last = l; ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic start_build();
    wbase = wa.size();
    xbase = n_xfer;
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_count", node_count, 0);
    chk("start_done", done, 0);
  endtask

  task automatic finish_check(input int n, input bit ovf);
    int k;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    chk("done", done, 1);
    chk("node_count", node_count, n);
    chk("head_addr", head_addr, BASE);
    chk("overflow", overflow, ovf);
    chk("busy_done", busy, 0);
    chk("ready_done", in_ready, 0);
    chk("n_writes", wa.size() - wbase, 2 * n);
    chk("n_xfers", n_xfer - xbase, n);
    for (k = 0; k < n; k++) begin
      if (wbase + 2 * k + 1 < wa.size()) begin
        chk("val_addr", wa[wbase+2*k], BASE + 2 * k);
        chk("val_data", wd[wbase+2*k], vals_q[k]);
        chk("link_addr", wa[wbase+2*k+1], BASE + 2 * k + 1);
        chk("link_data", wd[wbase+2*k+1], (k == n - 1) ? 0 : BASE + 2 * k + 2);
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_hold", done, 1);
      chk("count_hold", node_count, n);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_we", mem_we, 0);
  endtask

  task automatic run_list(input int exp_n, input bit exp_ovf, input int idle_max);
    bit ok;
    start_build();
    for (int i = 0; i < vals_q.size(); i++) begin
      if (i > exp_n) break;
      send(vals_q[i], last_q[i], $urandom_range(0, idle_max), ok);
      chk("accept", ok, (i < exp_n));
    end
    finish_check(exp_n, exp_ovf);
  endtask

  typedef struct {
    int            len;
    logic [DW-1:0] v[5];
    logic [4:0]    lmask;
    int            exp_n;
    bit            exp_ovf;
  } vec_t;

  vec_t tbl[5];

  function automatic vec_t mk(input int len, input logic [DW-1:0] a, b, c, d, e,
                              input logic [4:0] lm, input int en, input bit eo);
    vec_t r;
    r.len = len; r.v[0] = a; r.v[1] = b; r.v[2] = c; r.v[3] = d; r.v[4] = e;
    r.lmask = lm; r.exp_n = en; r.exp_ovf = eo;
    return r;
  endfunction

  task automatic load_vec(input vec_t t);
    vals_q.delete(); last_q.delete();
    for (int i = 0; i < t.len; i++) begin
      vals_q.push_back(t.v[i]);
      last_q.push_back(t.lmask[i]);
    end
  endtask

  initial begin
    bit ok;
    int n, len;
    bit ovf, any_last;

    tbl[0] = mk(3, 5, 7, 9, 0, 0, 5'b00100, 3, 0);
    tbl[1] = mk(1, 32'hA5, 0, 0, 0, 0, 5'b00001, 1, 0);
    tbl[2] = mk(5, 11, 22, 33, 44, 55, 5'b00000, 4, 1);
    tbl[3] = mk(5, 101, 102, 103, 104, 105, 5'b01000, 4, 0);
    tbl[4] = mk(3, 32'hDEAD, 32'hBEEF, 3, 0, 0, 5'b00001, 1, 0);

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_head", head_addr, 0);
    chk("rst_count", node_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      load_vec(tbl[t]);
      run_list(tbl[t].exp_n, tbl[t].exp_ovf, 1);
    end

    // in_valid toggles while writes are in progress
    vals_q = '{32'h1234, 32'h5678};
    last_q = '{1'b0, 1'b1};
    start_build();
    send(vals_q[0], 1'b0, 0, ok);
    chk("tog_accept0", ok, 1);
    in_valid = 1'b1; in_data = vals_q[1]; in_last = 1'b1;
    chk("tog_rdy_val", in_ready, 0);
    chk("tog_we_val", mem_we, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("tog_rdy_link", in_ready, 0);
    chk("tog_we_link", mem_we, 1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    send(vals_q[1], 1'b1, 0, ok);
    chk("tog_accept1", ok, 1);
    finish_check(2, 0);

    // reset in the middle of a value write
    vals_q = '{32'd77};
    last_q = '{1'b1};
    start_build();
    send(32'd77, 1'b1, 0, ok);
    chk("rstv_we_before", mem_we, 1);
    chk("rstv_addr_before", mem_addr, BASE);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstv_we", mem_we, 0);
    chk("rstv_busy", busy, 0);
    chk("rstv_head", head_addr, 0);
    chk("rstv_ready", in_ready, 0);
    chk("rstv_done", done, 0);
    chk("rstv_count", node_count, 0);
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    load_vec(tbl[0]);
    run_list(tbl[0].exp_n, tbl[0].exp_ovf, 0);

    // random lists against the reference model
    for (int r = 0; r < 25; r++) begin
      vals_q.delete(); last_q.delete();
      len = $urandom_range(1, 6);
      any_last = 1'b0;
      for (int i = 0; i < len; i++) begin
        vals_q.push_back($urandom);
        last_q.push_back(($urandom_range(0, 3) == 0));
        if (i < MAXN && last_q[i]) any_last = 1'b1;
      end
      if (!any_last && len <= MAXN) last_q[len-1] = 1'b1;
      model(n, ovf);
      run_list(n, ovf, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
